// File: rtl/cellrv32_cpu_cp_fpu_i2f.sv
// Integer (signed/unsigned 32-bit) to binary32 converter for FCVT.S.W / FCVT.S.WU.
// Normalises one bit per cycle, rounds per the RISC-V rounding mode, start/done pulse handshake.
module cellrv32_cpu_cp_fpu_i2f #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      rmode_i,
   input  logic            funct_i,
   input  logic [XLEN-1:0] rs1_i,
   output logic [31:0]     result_o,
   output logic [4:0]      flags_o,
   output logic            done_o
);

   localparam int unsigned FP_EXC_NX_C = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREPARE,
      S_NORMALIZE_BUSY,
      S_ROUND,
      S_FINALIZE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_mag;
   logic              r_unsign;
   logic              r_sign;
   logic [7:0]        r_exp;
   logic [31:0]       r_result;
   logic [4:0]        r_flags;
   logic              r_done;

   logic              w_sign;
   logic              w_g;
   logic              w_r;
   logic              w_s;
   logic              w_inexact;
   logic              w_inc;
   logic [23:0]       w_frac_raw;
   logic [24:0]       w_frac_sum;
   logic [23:0]       w_frac_rnd;
   logic [7:0]        w_exp_rnd;
   logic              w_accept;

   // The done cycle also accepts a new start so back-to-back issue costs no bubble.
   assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_FINALIZE));
   assign w_sign   = ~r_unsign & r_mag[XLEN-1];

   always_comb begin
      w_g        = r_mag[7];
      w_r        = r_mag[6];
      w_s        = |r_mag[5:0];
      w_inexact  = w_g | w_r | w_s;
      w_frac_raw = r_mag[XLEN-1:8];
      case (rmode_i)
         3'b000:  w_inc = w_g & (w_r | w_s | w_frac_raw[0]);
         3'b010:  w_inc = r_sign & w_inexact;
         3'b011:  w_inc = ~r_sign & w_inexact;
         3'b100:  w_inc = w_g;
         default: w_inc = 1'b0;
      endcase
      w_frac_sum = {1'b0, w_frac_raw} + {24'd0, w_inc};
      // Carry out only when the mantissa was all ones: renormalise to 1.0 and bump the exponent.
      w_frac_rnd = w_frac_sum[24] ? 24'h800000 : w_frac_sum[23:0];
      w_exp_rnd  = r_exp + {7'd0, w_frac_sum[24]};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:           if (start_i) w_state_nxt = S_PREPARE;
         S_PREPARE:        w_state_nxt = (r_mag == '0) ? S_FINALIZE : S_NORMALIZE_BUSY;
         S_NORMALIZE_BUSY: if (r_mag[XLEN-1]) w_state_nxt = S_ROUND;
         S_ROUND:          w_state_nxt = S_FINALIZE;
         S_FINALIZE:       w_state_nxt = start_i ? S_PREPARE : S_IDLE;
         default:          w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mag    <= '0;
         r_unsign <= 1'b0;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_result <= '0;
         r_flags  <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_mag    <= rs1_i;
            r_unsign <= funct_i;
         end
         case (r_state)
            S_PREPARE: begin
               r_sign <= w_sign;
               if (w_sign) r_mag <= '0 - r_mag;
               r_exp <= 8'd158;
               if (r_mag == '0) begin
                  r_result <= '0;
                  r_flags  <= '0;
                  r_done   <= 1'b1;
               end
            end
            S_NORMALIZE_BUSY: begin
               if (!r_mag[XLEN-1]) begin
                  r_mag <= r_mag << 1;
                  r_exp <= r_exp - 8'd1;
               end
            end
            S_ROUND: begin
               // Result is formed here so it is valid in the same cycle done_o is high.
               r_result             <= {r_sign, w_exp_rnd, w_frac_rnd[22:0]};
               r_flags              <= '0;
               r_flags[FP_EXC_NX_C] <= w_inexact;
               r_done               <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result_o = r_result;
   assign flags_o  = r_flags;
   assign done_o   = r_done;

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu_i2f.sv
// Directed-vector bench for the integer-to-binary32 converter.
module tb_cellrv32_cpu_cp_fpu_i2f;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  rmode;
   logic        funct;
   logic [31:0] rs1;
   logic [31:0] result;
   logic [4:0]  flags;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   cellrv32_cpu_cp_fpu_i2f #(.XLEN(32)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .rmode_i  (rmode),
      .funct_i  (funct),
      .rs1_i    (rs1),
      .result_o (result),
      .flags_o  (flags),
      .done_o   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one conversion; edges are counted from the edge that samples start.
   task automatic convert(input string tag, input logic [31:0] a, input logic f,
                          input logic [2:0] rm, input logic [31:0] er,
                          input logic [4:0] ef, input int ee);
      int edge_n;
      edge_n = 0;
      rs1 = a; funct = f; rmode = rm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 2; e <= 100 && edge_n == 0; e++) begin
         @(posedge clk); #1;
         if (done) edge_n = e;
      end
      chk_eq({tag, " done_edge"}, edge_n, ee);
      if (edge_n != 0) begin
         chk_eq({tag, " result"}, result, er);
         chk_eq({tag, " flags"}, {27'd0, flags}, {27'd0, ef});
         @(posedge clk); #1;
         chk_eq({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      int dn;
      rst = 1'b1; start = 1'b0; rmode = 3'b000; funct = 1'b0; rs1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst result", result, 32'h0);
      chk_eq("rst flags", {27'd0, flags}, 32'h0);
      chk_eq("rst done", {31'd0, done}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      convert("s_one",      32'h00000001, 1'b0, 3'b000, 32'h3F800000, 5'b00000, 35);
      convert("s_neg_one",  32'hFFFFFFFF, 1'b0, 3'b000, 32'hBF800000, 5'b00000, 35);
      convert("s_zero",     32'h00000000, 1'b0, 3'b000, 32'h00000000, 5'b00000, 2);
      convert("s_min",      32'h80000000, 1'b0, 3'b000, 32'hCF000000, 5'b00000, 4);
      convert("u_2p31",     32'h80000000, 1'b1, 3'b000, 32'h4F000000, 5'b00000, 4);
      convert("u_max_rne",  32'hFFFFFFFF, 1'b1, 3'b000, 32'h4F800000, 5'b10000, 4);
      convert("u_max_rtz",  32'hFFFFFFFF, 1'b1, 3'b001, 32'h4F7FFFFF, 5'b10000, 4);
      convert("tie_rne",    32'h01000001, 1'b1, 3'b000, 32'h4B800000, 5'b10000, 11);
      convert("tie_rup",    32'h01000001, 1'b1, 3'b011, 32'h4B800001, 5'b10000, 11);
      convert("tie_rdn",    32'h01000001, 1'b1, 3'b010, 32'h4B800000, 5'b10000, 11);
      convert("tie_rmm",    32'h01000001, 1'b1, 3'b100, 32'h4B800001, 5'b10000, 11);
      convert("neg_rdn",    32'hFEFFFFFF, 1'b0, 3'b010, 32'hCB800001, 5'b10000, 11);
      convert("neg_rup",    32'hFEFFFFFF, 1'b0, 3'b011, 32'hCB800000, 5'b10000, 11);
      convert("rsv_mode",   32'h01000001, 1'b1, 3'b111, 32'h4B800000, 5'b10000, 11);

      // start held high through most of a busy conversion
      dn = 0;
      rs1 = 32'h00000001; funct = 1'b0; rmode = 3'b000; start = 1'b1;
      for (int e = 1; e <= 80; e++) begin
         @(posedge clk); #1;
         if (e == 20) start = 1'b0;
         if (done) dn++;
      end
      chk_eq("held_start done_count", dn, 1);
      chk_eq("held_start result", result, 32'h3F800000);

      // reset sampled on the 10th edge of a conversion
      dn = 0;
      rs1 = 32'h00000001; funct = 1'b0; rmode = 3'b000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 2; e <= 9; e++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_eq("abort result", result, 32'h0);
      chk_eq("abort flags", {27'd0, flags}, 32'h0);
      for (int e = 0; e < 50; e++) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      chk_eq("abort done_count", dn, 0);

      convert("after_rst",  32'h00000001, 1'b0, 3'b000, 32'h3F800000, 5'b00000, 35);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
